// File: rtl/nios_system_pio_master_if.sv
// Bundle of command, response and Avalon-MM bus signals for the PIO master.
// The master modport is the initiator's view. The slave modport is the
// environment's view: command producer, response consumer and bus slave.
interface nios_system_pio_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] address;
  logic                  chipselect;
  logic                  write_n;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready, readdata,
    output cmd_ready, rsp_valid, rsp_data, address, chipselect, write_n, writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready, readdata,
    input  cmd_ready, rsp_valid, rsp_data, address, chipselect, write_n, writedata
  );
endinterface

// File: rtl/nios_system_pio_master.sv
// Single-outstanding Avalon-MM initiator for PIO-style registers.
// A command is latched in IDLE, strobed on the bus for one cycle, and for
// reads the slave data is captured READ_LATENCY clocks after the strobe and
// held on the response channel until the consumer takes it.
module nios_system_pio_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  nios_system_pio_master_if.master bus,
  output logic busy
);

  // Out-of-range latencies fall back to 1 so the 2-bit counter never wraps.
  localparam int          LAT_EFF  = (READ_LATENCY >= 1 && READ_LATENCY <= 4) ? READ_LATENCY : 1;
  localparam logic [1:0]  CNT_LOAD = 2'(LAT_EFF - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] writedata_q, writedata_d;
  logic                  chipselect_q, chipselect_d;
  logic                  write_n_q, write_n_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Next-state and next-output decode; the strobe is computed one cycle
  // ahead so chipselect/write_n come straight from flops.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    chipselect_d = 1'b0;
    write_n_d    = 1'b1;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          address_d    = bus.cmd_address;
          chipselect_d = 1'b1;
          if (bus.cmd_write) begin
            writedata_d = bus.cmd_wdata;
            write_n_d   = 1'b0;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      READ: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rsp_data_d  = bus.readdata;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      address_q    <= '0;
      writedata_q  <= '0;
      chipselect_q <= 1'b0;
      write_n_q    <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      chipselect_q <= chipselect_d;
      write_n_q    <= write_n_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign bus.address    = address_q;
  assign bus.writedata  = writedata_q;
  assign bus.chipselect = chipselect_q;
  assign bus.write_n    = write_n_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_nios_system_pio_master.sv
// Testbench for nios_system_pio_master: one instance at read latency 1 backed
// by a small PIO register file, one at read latency 3 backed by a slave whose
// readdata advances every clock.
module tb_nios_system_pio_master;

  localparam int DW = 32;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset;
  logic busy1, busy3;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cycles = 0;
  int num_cmds = 0;

  logic [31:0] slave_mem [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] ref_mem   [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] tick = 32'd1;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  nios_system_pio_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  nios_system_pio_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

  nios_system_pio_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1),
    .busy  (busy1)
  );

  nios_system_pio_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3),
    .busy  (busy3)
  );

  // Cycle counter used to measure strobe spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Every clock with chipselect high is one bus strobe cycle on the latency-1 bus.
  always @(posedge clk) if (bus1.chipselect === 1'b1) strobe_cycles <= strobe_cycles + 1;

  // Latency-1 PIO slave: writes on a write strobe, registers readdata on any select.
  always @(posedge clk) begin
    if (bus1.chipselect === 1'b1) begin
      if (bus1.write_n === 1'b0) slave_mem[bus1.address] <= bus1.writedata;
      bus1.readdata <= slave_mem[bus1.address];
    end
  end

  // Latency-3 slave: readdata is simply a counter that advances every clock.
  always @(posedge clk) tick <= tick + 32'd1;
  assign bus3.readdata = tick;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] addr, input logic [31:0] data);
    bus1.cmd_valid   = 1'b1;
    bus1.cmd_write   = wr;
    bus1.cmd_address = addr;
    bus1.cmd_wdata   = data;
  endtask

  // One write on the latency-1 instance, checked cycle by cycle.
  task automatic doWrite(input logic [1:0] addr, input logic [31:0] data);
    checkOutput("wr_ready_before", 32'(bus1.cmd_ready), 32'd1);
    applyStimulus(1'b1, addr, data);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    num_cmds++;
    checkOutput("wr_cs", 32'(bus1.chipselect), 32'd1);
    checkOutput("wr_write_n", 32'(bus1.write_n), 32'd0);
    checkOutput("wr_address", 32'(bus1.address), 32'(addr));
    checkOutput("wr_writedata", bus1.writedata, data);
    checkOutput("wr_ready_busy", 32'(bus1.cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("wr_cs_after", 32'(bus1.chipselect), 32'd0);
    checkOutput("wr_write_n_after", 32'(bus1.write_n), 32'd1);
    checkOutput("wr_ready_after", 32'(bus1.cmd_ready), 32'd1);
    checkOutput("wr_writedata_hold", bus1.writedata, data);
    ref_mem[addr] = data;
  endtask

  // One read on the latency-1 instance with a given number of stall cycles.
  task automatic doRead(input logic [1:0] addr, input int stall);
    int waited;
    logic [31:0] held;
    checkOutput("rd_ready_before", 32'(bus1.cmd_ready), 32'd1);
    applyStimulus(1'b0, addr, $urandom);
    bus1.rsp_ready = 1'b0;
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    num_cmds++;
    checkOutput("rd_cs", 32'(bus1.chipselect), 32'd1);
    checkOutput("rd_write_n", 32'(bus1.write_n), 32'd1);
    checkOutput("rd_address", 32'(bus1.address), 32'(addr));
    waited = 1;
    while (bus1.rsp_valid !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rd_latency", 32'(waited), 32'd3);
    checkOutput("rd_data", bus1.rsp_data, ref_mem[addr]);
    held = bus1.rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("rd_stall_valid", 32'(bus1.rsp_valid), 32'd1);
      checkOutput("rd_stall_data", bus1.rsp_data, held);
      checkOutput("rd_stall_ready", 32'(bus1.cmd_ready), 32'd0);
    end
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    checkOutput("rd_valid_after", 32'(bus1.rsp_valid), 32'd0);
    checkOutput("rd_ready_after", 32'(bus1.cmd_ready), 32'd1);
  endtask

  // Directed sequence followed by a randomized mix against the register model.
  initial begin
    int sc [3];
    logic [31:0] bd [3];
    logic [31:0] t0;
    logic [31:0] nxt;
    int waited;

    reset = 1'b1;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_write = 1'b1;
    bus1.cmd_address = 2'd3;
    bus1.cmd_wdata = 32'hDEADBEEF;
    bus1.rsp_ready = 1'b0;
    bus3.cmd_valid = 1'b0;
    bus3.cmd_write = 1'b0;
    bus3.cmd_address = 2'd0;
    bus3.cmd_wdata = 32'd0;
    bus3.rsp_ready = 1'b0;

    // Reset held for two clocks with a pending command.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst_cs", 32'(bus1.chipselect), 32'd0);
      checkOutput("rst_write_n", 32'(bus1.write_n), 32'd1);
      checkOutput("rst_address", 32'(bus1.address), 32'd0);
      checkOutput("rst_writedata", bus1.writedata, 32'd0);
      checkOutput("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
      checkOutput("rst_rsp_data", bus1.rsp_data, 32'd0);
      checkOutput("rst_busy", 32'(busy1), 32'd0);
    end
    reset = 1'b0;
    bus1.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(bus1.cmd_ready), 32'd1);
    checkOutput("rst_strobes", 32'(strobe_cycles), 32'd0);

    // Single write to the 11-bit LED port.
    doWrite(2'd0, 32'h5A5);
    checkOutput("out_port", {21'd0, slave_mem[0][10:0]}, 32'h5A5);

    // Three back-to-back writes must strobe every second clock.
    for (int i = 0; i < 3; i++) bd[i] = $urandom;
    applyStimulus(1'b1, 2'd1, bd[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("b2b_cs", 32'(bus1.chipselect), 32'd1);
      checkOutput("b2b_writedata", bus1.writedata, bd[i]);
      sc[i] = cyc;
      ref_mem[i + 1] = bd[i];
      num_cmds++;
      if (i < 2) applyStimulus(1'b1, 2'(i + 2), bd[i + 1]);
      else bus1.cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("b2b_gap_cs", 32'(bus1.chipselect), 32'd0);
      checkOutput("b2b_gap_ready", 32'(bus1.cmd_ready), 32'd1);
    end
    checkOutput("b2b_spacing01", 32'(sc[1] - sc[0]), 32'd2);
    checkOutput("b2b_spacing12", 32'(sc[2] - sc[1]), 32'd2);

    // Read of a known value at latency 1.
    doWrite(2'd0, 32'h0000_03FF);
    doRead(2'd0, 0);

    // Backpressure with the next command already waiting during RESP.
    doWrite(2'd2, 32'hCAFE_0002);
    applyStimulus(1'b0, 2'd2, 32'd0);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    num_cmds++;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_valid_rise", 32'(bus1.rsp_valid), 32'd1);
    checkOutput("bp_data", bus1.rsp_data, 32'hCAFE_0002);
    nxt = $urandom;
    applyStimulus(1'b1, 2'd1, nxt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(bus1.rsp_valid), 32'd1);
      checkOutput("bp_data_hold", bus1.rsp_data, 32'hCAFE_0002);
      checkOutput("bp_ready", 32'(bus1.cmd_ready), 32'd0);
      checkOutput("bp_cs", 32'(bus1.chipselect), 32'd0);
    end
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    checkOutput("bp_consumed", 32'(bus1.rsp_valid), 32'd0);
    checkOutput("bp_idle_ready", 32'(bus1.cmd_ready), 32'd1);
    checkOutput("bp_not_same_edge", 32'(bus1.chipselect), 32'd0);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    num_cmds++;
    ref_mem[1] = nxt;
    checkOutput("bp_next_cs", 32'(bus1.chipselect), 32'd1);
    checkOutput("bp_next_write_n", 32'(bus1.write_n), 32'd0);
    checkOutput("bp_next_data", bus1.writedata, nxt);
    @(negedge clk);

    // Latency-3 instance: captured data is the counter value 3 cycles after the strobe cycle.
    bus3.cmd_valid = 1'b1;
    bus3.cmd_write = 1'b0;
    bus3.cmd_address = 2'd1;
    t0 = tick;
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    checkOutput("l3_cs", 32'(bus3.chipselect), 32'd1);
    waited = 1;
    while (bus3.rsp_valid !== 1'b1 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("l3_latency", 32'(waited), 32'd5);
    checkOutput("l3_data", bus3.rsp_data, t0 + 32'd4);
    bus3.rsp_ready = 1'b1;
    @(negedge clk);
    bus3.rsp_ready = 1'b0;
    checkOutput("l3_consumed", 32'(bus3.rsp_valid), 32'd0);

    // Reset while the latency-1 read is waiting for data.
    applyStimulus(1'b0, 2'd0, 32'd0);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    num_cmds++;
    checkOutput("mid_cs", 32'(bus1.chipselect), 32'd1);
    @(negedge clk);
    checkOutput("mid_busy", 32'(busy1), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_busy_rst", 32'(busy1), 32'd0);
    checkOutput("mid_ready_rst", 32'(bus1.cmd_ready), 32'd1);
    checkOutput("mid_cs_rst", 32'(bus1.chipselect), 32'd0);
    checkOutput("mid_addr_rst", 32'(bus1.address), 32'd0);
    checkOutput("mid_wdata_rst", bus1.writedata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mid_no_rsp", 32'(bus1.rsp_valid), 32'd0);
      @(negedge clk);
    end
    doRead(2'd2, 1);

    // Randomized mix of writes and reads with random backpressure.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) doWrite(2'($urandom_range(0, 3)), $urandom);
      else doRead(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    checkOutput("strobe_count", 32'(strobe_cycles), 32'(num_cmds));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
